// File: rtl/ad_fft_pkg.sv
// ============================================================================
// Module : ad_fft_pkg
// Brief  : Shared types, defaults and word packing for the ADC FFT path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ad_fft_pkg;

    localparam int AD_DATA_W = 16;
    localparam int AD_NCH    = 7;

    typedef logic [1:0] fsm_state_t;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FILL   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    // Each channel becomes {real, zero imaginary}; channel 1 stays in the MSBs.
    function automatic logic [2*AD_NCH*AD_DATA_W-1:0] pack_re_zero_im(
        input logic [AD_NCH*AD_DATA_W-1:0] s
    );
        logic [2*AD_NCH*AD_DATA_W-1:0] w;
        w = '0;
        for (int c = 0; c < AD_NCH; c++) begin
            w[c*2*AD_DATA_W +: 2*AD_DATA_W] = {s[c*AD_DATA_W +: AD_DATA_W], {AD_DATA_W{1'b0}}};
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ad_fft_feeder_if.sv
// ============================================================================
// Module : ad_fft_feeder_if
// Brief  : AXI-Stream link from the frame feeder into the FFT data slave.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ad_fft_feeder_if
    import ad_fft_pkg::*;
#(
    parameter int DATA_W = AD_DATA_W,
    parameter int NCH    = AD_NCH
) ();

    logic [2*NCH*DATA_W-1:0] m_tdata;
    logic                    m_tvalid;
    logic                    m_tready;
    logic                    m_tlast;

    modport master (output m_tdata, output m_tvalid, output m_tlast, input  m_tready);
    modport slave  (input  m_tdata, input  m_tvalid, input  m_tlast, output m_tready);

endinterface

`default_nettype wire

// File: rtl/ad_frame_ram.sv
// ============================================================================
// Module : ad_frame_ram
// Brief  : Simple dual-port frame buffer with a registered, enabled read port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ad_frame_ram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int WIDTH  = 112
) (
    input  wire logic              clk,
    input  wire logic              wr_en_i,
    input  wire logic [ADDR_W-1:0] wr_addr_i,
    input  wire logic [WIDTH-1:0]  wr_data_i,
    input  wire logic              rd_en_i,
    input  wire logic [ADDR_W-1:0] rd_addr_i,
    output logic      [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Read data holds while rd_en_i is low; the feeder relies on this to park a prefetched word.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

`default_nettype wire

// File: rtl/ad_fft_feeder.sv
// ============================================================================
// Module : ad_fft_feeder
// Brief  : Captures one 7-channel ADC frame and streams it to the FFT core.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ad_fft_feeder
    import ad_fft_pkg::*;
#(
    parameter int DATA_W     = AD_DATA_W,
    parameter int NCH        = AD_NCH,
    parameter int FRAME_LEN  = 1024,
    parameter int ADDR_W     = 10,
    parameter bit OFFSET_BIN = 1'b1
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  arm,
    input  wire logic                  cont,
    input  wire logic                  adc_valid,
    input  wire logic [NCH*DATA_W-1:0] adc_data,
    ad_fft_feeder_if.master            m,
    output logic                       busy,
    output logic                       frame_done,
    output logic [15:0]                drop_cnt
);

    logic [1:0]              state_q, state_d;
    logic [ADDR_W-1:0]       wr_ptr_q;
    logic [ADDR_W:0]         rd_cnt_q;
    logic                    pf_vld_q, pf_last_q;
    logic                    out_vld_q, out_last_q;
    logic [2*NCH*DATA_W-1:0] out_data_q;
    logic                    frame_done_q;
    logic [15:0]             drop_cnt_q;

    logic [NCH*DATA_W-1:0]   wr_word;
    logic [NCH*DATA_W-1:0]   ram_rd;
    logic [2*NCH*DATA_W-1:0] packed_word;
    logic                    wr_en, last_wr, hs, last_hs, out_load, rd_en;

    always_comb begin
        wr_word = adc_data;
        if (OFFSET_BIN) begin
            for (int c = 0; c < NCH; c++) begin
                wr_word[c*DATA_W + DATA_W - 1] = ~adc_data[c*DATA_W + DATA_W - 1];
            end
        end
    end

    assign wr_en    = (state_q == ST_FILL) && adc_valid;
    assign last_wr  = wr_en && (wr_ptr_q == ADDR_W'(FRAME_LEN - 1));
    assign hs       = out_vld_q && m.m_tready;
    assign last_hs  = hs && out_last_q;
    // Two-stage pipe: RAM output word (prefetch) feeding the AXI output register.
    assign out_load = pf_vld_q && (!out_vld_q || m.m_tready);
    assign rd_en    = (state_q == ST_STREAM) && (rd_cnt_q != (ADDR_W+1)'(FRAME_LEN))
                      && (!pf_vld_q || out_load);

    ad_frame_ram #(
        .DEPTH  (FRAME_LEN),
        .ADDR_W (ADDR_W),
        .WIDTH  (NCH*DATA_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_word),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_cnt_q[ADDR_W-1:0]),
        .rd_data_o (ram_rd)
    );

    if (DATA_W == AD_DATA_W && NCH == AD_NCH) begin : g_pkg_pack
        assign packed_word = pack_re_zero_im(ram_rd);
    end else begin : g_gen_pack
        for (genvar c = 0; c < NCH; c++) begin : g_ch
            assign packed_word[c*2*DATA_W +: 2*DATA_W] = {ram_rd[c*DATA_W +: DATA_W], {DATA_W{1'b0}}};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (arm)     state_d = ST_FILL;
            ST_FILL:   if (last_wr) state_d = ST_STREAM;
            ST_STREAM: if (last_hs) state_d = cont ? ST_FILL : ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_cnt_q     <= '0;
            pf_vld_q     <= 1'b0;
            pf_last_q    <= 1'b0;
            out_vld_q    <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= last_hs;

            if ((state_q == ST_IDLE && arm) || last_hs) begin
                wr_ptr_q <= '0;
            end else if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end

            if (last_wr) begin
                rd_cnt_q <= '0;
                pf_vld_q <= 1'b0;
            end else if (rd_en) begin
                rd_cnt_q <= rd_cnt_q + (ADDR_W+1)'(1);
                pf_vld_q <= 1'b1;
            end else if (out_load) begin
                pf_vld_q <= 1'b0;
            end

            if (rd_en) begin
                pf_last_q <= (rd_cnt_q == (ADDR_W+1)'(FRAME_LEN - 1));
            end

            if (out_load) begin
                out_vld_q  <= 1'b1;
                out_last_q <= pf_last_q;
                out_data_q <= packed_word;
            end else if (m.m_tready) begin
                out_vld_q  <= 1'b0;
                out_last_q <= 1'b0;
            end

            if (adc_valid && state_q != ST_FILL && drop_cnt_q != 16'hFFFF) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign m.m_tdata  = out_data_q;
    assign m.m_tvalid = out_vld_q;
    assign m.m_tlast  = out_last_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ad_fft_feeder.sv
// ============================================================================
// Module : tb_ad_fft_feeder
// Brief  : Directed self-checking bench for ad_fft_feeder with an 8-sample frame.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ad_fft_feeder;

    localparam int FL = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         arm = 1'b0, cont = 1'b0, adc_valid = 1'b0;
    logic [111:0] adc_data = '0;
    logic         busy, frame_done;
    logic [15:0]  drop_cnt;

    logic         arm2 = 1'b0, adc_valid2 = 1'b0;
    logic [111:0] adc_data2 = '0;
    logic         busy2, frame_done2;
    logic [15:0]  drop_cnt2;

    int total = 0;
    int bad   = 0;

    ad_fft_feeder_if #(.DATA_W(16), .NCH(7)) axis  ();
    ad_fft_feeder_if #(.DATA_W(16), .NCH(7)) axis2 ();

    ad_fft_feeder #(.DATA_W(16), .NCH(7), .FRAME_LEN(FL), .ADDR_W(3), .OFFSET_BIN(1'b1)) dut (
        .clk(clk), .reset(reset), .arm(arm), .cont(cont), .adc_valid(adc_valid),
        .adc_data(adc_data), .m(axis), .busy(busy), .frame_done(frame_done), .drop_cnt(drop_cnt)
    );

    ad_fft_feeder #(.DATA_W(16), .NCH(7), .FRAME_LEN(FL), .ADDR_W(3), .OFFSET_BIN(1'b0)) dut2 (
        .clk(clk), .reset(reset), .arm(arm2), .cont(1'b0), .adc_valid(adc_valid2),
        .adc_data(adc_data2), .m(axis2), .busy(busy2), .frame_done(frame_done2), .drop_cnt(drop_cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Input: ch k = 8000 + base + 16k + n (offset binary); output: ch k re = base + 16k + n.
    function automatic logic [111:0] mk_in(input int base, input int n);
        logic [111:0] w;
        for (int k = 1; k <= 7; k++) w[(7-k)*16 +: 16] = 16'(32'h8000 + base + k*16 + n);
        return w;
    endfunction

    function automatic logic [223:0] mk_out(input int base, input int n);
        logic [223:0] w;
        for (int k = 1; k <= 7; k++) w[(7-k)*32 +: 32] = {16'(base + k*16 + n), 16'h0000};
        return w;
    endfunction

    // Beat monitor: samples mid-cycle, logs handshakes and verifies hold during stalls.
    logic [223:0] q_data[$];
    logic         q_last[$];
    int           done_cnt = 0;
    bit           prev_stall = 1'b0;
    logic [223:0] prev_data;
    logic         prev_last;

    always begin
        @(negedge clk);
        #2;
        if (prev_stall) begin
            chk("stall_vld",  axis.m_tvalid, 1'b1);
            chk("stall_data", axis.m_tdata,  prev_data);
            chk("stall_last", axis.m_tlast,  prev_last);
        end
        prev_stall = axis.m_tvalid & ~axis.m_tready & reset;
        prev_data  = axis.m_tdata;
        prev_last  = axis.m_tlast;
        if (axis.m_tvalid === 1'b1 && axis.m_tready === 1'b1) begin
            q_data.push_back(axis.m_tdata);
            q_last.push_back(axis.m_tlast);
        end
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic do_arm();
        @(negedge clk); arm = 1'b1;
        @(negedge clk); arm = 1'b0;
    endtask

    task automatic drive_frame(input int base);
        for (int n = 0; n < FL; n++) begin
            @(negedge clk); adc_valid = 1'b1; adc_data = mk_in(base, n);
        end
        @(negedge clk); adc_valid = 1'b0;
    endtask

    task automatic drive_drops(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk); adc_valid = 1'b1; adc_data = 112'h1234;
        end
        @(negedge clk); adc_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 200) begin
            @(negedge clk); n++;
        end
        chk("done_wait", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic check_frames(input string tag, input int nfr, input int base0, input int step);
        chk({tag, "_cnt"}, 32'(q_data.size()), 32'(nfr*FL));
        for (int j = 0; j < q_data.size() && j < nfr*FL; j++) begin
            chk({tag, "_data"}, q_data[j], mk_out(base0 + (j/FL)*step, j%FL));
            chk({tag, "_last"}, q_last[j], 1'((j%FL) == FL-1));
        end
    endtask

    initial begin #200000; $display("FAIL watchdog timeout"); $fatal(1); end

    initial begin
        int exp_done;
        int beats;
        int n;
        bit rpat [6];
        logic [15:0] v;
        rpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        axis.m_tready  = 1'b1;
        axis2.m_tready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_tvalid", axis.m_tvalid, 1'b0);
        chk("rst_tlast",  axis.m_tlast,  1'b0);
        chk("rst_tdata",  axis.m_tdata,  224'h0);
        chk("rst_busy",   busy,          1'b0);
        chk("rst_done",   frame_done,    1'b0);
        chk("rst_drop",   drop_cnt,      16'h0);
        reset = 1'b1;

        // Ramp, ready held high: exact latency, no bubbles, tlast and frame_done timing.
        do_arm();
        chk("arm_busy", busy, 1'b1);
        drive_frame(0);
        chk("lat0_vld", axis.m_tvalid, 1'b0);
        @(negedge clk);
        chk("lat1_vld", axis.m_tvalid, 1'b0);
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            chk("ramp_vld",  axis.m_tvalid, 1'b1);
            chk("ramp_data", axis.m_tdata,  mk_out(0, i));
            chk("ramp_last", axis.m_tlast,  1'(i == FL-1));
        end
        @(negedge clk);
        chk("ramp_done",  frame_done,    1'b1);
        chk("ramp_end_v", axis.m_tvalid, 1'b0);
        chk("ramp_busy",  busy,          1'b0);
        @(negedge clk);
        chk("ramp_done1", frame_done,    1'b0);
        exp_done = 1;

        // Backpressure pattern on m_tready.
        q_data.delete(); q_last.delete();
        do_arm();
        drive_frame(16'h0100);
        n = 0;
        while (done_cnt < exp_done + 1 && n < 200) begin
            axis.m_tready = rpat[n % 6];
            @(negedge clk); n++;
        end
        axis.m_tready = 1'b1;
        exp_done++;
        chk("bp_to", 32'(done_cnt), 32'(exp_done));
        check_frames("bp", 1, 16'h0100, 0);

        // Drops outside FILL; arm coincident with a strobe in IDLE.
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        chk("drop_rst", drop_cnt, 16'h0);
        q_data.delete(); q_last.delete();
        drive_drops(2);
        @(negedge clk); arm = 1'b1; adc_valid = 1'b1; adc_data = 112'h5555;
        @(negedge clk); arm = 1'b0; adc_valid = 1'b0;
        chk("drop_idle", drop_cnt, 16'd3);
        drive_frame(16'h0200);
        drive_drops(2);
        exp_done++;
        wait_done(exp_done);
        chk("drop_cnt", drop_cnt, 16'd5);
        check_frames("drop", 1, 16'h0200, 0);

        // Continuous mode: one arm, three frames, strobes during STREAM are drops.
        q_data.delete(); q_last.delete();
        cont = 1'b1;
        do_arm();
        for (int f = 0; f < 3; f++) begin
            drive_frame(16'h0300 + f*16'h0100);
            if (f == 2) cont = 1'b0;
            drive_drops(2);
            exp_done++;
            wait_done(exp_done);
            chk("cont_busy", busy, 1'(f != 2));
        end
        chk("cont_done", 32'(done_cnt), 32'(exp_done));
        chk("cont_drop", drop_cnt, 16'd11);
        check_frames("cont", 3, 16'h0300, 16'h0100);

        // Reset while beat 3 is on the bus, then a clean frame.
        q_data.delete(); q_last.delete();
        do_arm();
        drive_frame(16'h0600);
        n = 0;
        while (q_data.size() < 3 && n < 50) begin @(negedge clk); n++; end
        chk("mid_beats", 32'(q_data.size()), 32'd3);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_vld",  axis.m_tvalid, 1'b0);
        chk("mid_busy", busy,          1'b0);
        chk("mid_drop", drop_cnt,      16'h0);
        reset = 1'b1;
        q_data.delete(); q_last.delete();
        done_cnt = 0; exp_done = 0;
        do_arm();
        drive_frame(16'h0700);
        exp_done++;
        wait_done(exp_done);
        check_frames("post", 1, 16'h0700, 0);

        // Two's-complement input passes through unchanged.
        @(negedge clk); arm2 = 1'b1;
        @(negedge clk); arm2 = 1'b0;
        for (int i = 0; i < FL; i++) begin
            v = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
            @(negedge clk); adc_valid2 = 1'b1; adc_data2 = {7{v}};
        end
        @(negedge clk); adc_valid2 = 1'b0;
        beats = 0;
        for (int c = 0; c < 40 && beats < FL; c++) begin
            @(negedge clk);
            if (axis2.m_tvalid === 1'b1) begin
                v = (beats % 2 == 0) ? 16'h7FFF : 16'h8000;
                chk("ob0_data", axis2.m_tdata, {7{v, 16'h0000}});
                beats++;
            end
        end
        chk("ob0_cnt", 32'(beats), 32'(FL));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
